fir_stream_p: RTL and testbench
===============================

FIR_STREAM_P -- requirements
Module: fir_stream_p

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning signed input sample width, Q8.8.
REQ-002 SHALL have parameter COEF_W, default 20, meaning signed coefficient width, Q4.16.
REQ-003 SHALL have parameter TAPS, default 32, meaning filter length (power of 2 required, minimum 2).
REQ-004 SHALL have parameter OUT_W, default 16, meaning signed output width, Q8.8.
REQ-005 SHALL have parameter SHIFT, default 16, meaning right shift applied to the accumulator to produce the output.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-008 SHALL have port data_valid, input, 1 bit, sample qualifier.
REQ-009 SHALL have port data, input, DATA_W bits, input sample.
REQ-010 SHALL have port coef_we, input, 1 bit, coefficient write strobe.
REQ-011 SHALL have port coef_addr, input, $clog2(TAPS) bits, tap index k.
REQ-012 SHALL have port coef_wdata, input, COEF_W bits, coefficient value.
REQ-013 SHALL have port fir_valid, output, 1 bit, one-cycle strobe per valid output.
REQ-014 SHALL have port fir_d, output, OUT_W bits, filtered sample.
REQ-015 SHALL have port sat, output, 1 bit, sticky saturation flag.

Function
REQ-016 SHALL shift data into a TAPS-deep delay line only in cycles with data_valid=1; x[0] is the newest sample.
REQ-017 SHALL compute y = sum over k of c[k]*x[k], with the accumulator full width DATA_W+COEF_W+$clog2(TAPS), signed.
REQ-018 SHALL use a fixed pipeline: products registered at +1, adder-tree sum at +2, fir_d/fir_valid at +3 cycles after the accepting edge.
REQ-019 SHALL propagate a valid tag with the pipeline, with no stall; gaps in data_valid produce matching gaps in fir_valid.
REQ-020 SHALL hold fir_valid=0 until TAPS samples have been accepted (warm-up counter saturating at TAPS); the first valid output corresponds to the TAPS-th sample.
REQ-021 SHALL scale as acc >>> SHIFT (arithmetic), then saturate to the OUT_W signed range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-022 SHALL set sat to 1 on any clamped valid output; sat stays 1 until reset.
REQ-023 SHALL hold fir_d at its last value while fir_valid=0.
REQ-024 SHALL write c[coef_addr] on a coef_we edge; a sample accepted on that same edge uses the old coefficients, and later samples use the new value.
REQ-025 SHALL ignore coef_we for coef_addr >= TAPS, which can occur only when TAPS is not a power of 2.

Reset
REQ-026 SHALL, when rst=0, immediately clear the delay line, coefficients, pipeline, warm-up counter, fir_valid, fir_d and sat to 0.
REQ-027 SHALL, after reset is released mid-stream, require TAPS new samples before fir_valid may rise; samples in flight at reset are discarded.

Configuration
REQ-028 SHALL, with macro FIR_ROUND_EN defined, add 2^(SHIFT-1) to acc before the shift (round half up).
REQ-029 SHALL, with FIR_ROUND_EN undefined, truncate toward minus infinity (plain arithmetic shift); the latency is identical in both builds.

Verification
REQ-030 SHALL cover warm-up: default parameters, all c=0x10000, 31 samples of 0x0100 -> fir_valid never 1; 32nd sample -> fir_valid=1 exactly 3 cycles later with fir_d=0x2000.
REQ-031 SHALL cover impulse: c[k]=k*0x1000, 31 zeros, then 0x0100, then zeros -> successive valid fir_d = k*0x0010 for k=0..31, then 0x0000.
REQ-032 SHALL cover saturation: all c=0x10000, constant input 0x7FFF -> fir_d=0x7FFF and sat=1 from the first valid output; then input 0x8000 -> fir_d=0x8000.
REQ-033 SHALL cover rounding: c[0]=0x08000, others 0 -> input 0x0001 gives 0x0001 with FIR_ROUND_EN and 0x0000 without; input 0xFFFF gives 0x0000 with FIR_ROUND_EN and 0xFFFF without.
REQ-034 SHALL cover gapped input and reset: data_valid on every other cycle -> fir_d sequence identical to the continuous run, fir_valid count = accepted samples - 31; rst=0 mid-stream -> fir_valid=0, fir_d=0, sat=0 at once, and c must be reloaded.
REQ-035 SHALL cover coefficient-write collision: coef_we and data_valid on the same edge -> that sample's output uses the old c, and the next sample's output uses the new c.

Source files
------------

// File: rtl/fir_stream_p.sv
// fir_stream_p -- streaming direct-form FIR filter with a fixed 3-cycle pipeline.
//
// Each sample accepted with data_valid=1 enters a TAPS-deep delay line. The
// products c[k]*x[k] are registered one cycle later. The adder-tree sum is
// registered one cycle after that. The scaled and saturated result appears on
// fir_d together with a one-cycle fir_valid strobe three cycles after the
// accepting edge. The pipeline never stalls, so gaps in data_valid produce
// matching gaps in fir_valid. No output is flagged valid until TAPS samples
// have been accepted since reset.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - asynchronous reset, active low; clears all state
//   data_valid - sample qualifier
//   data       - input sample, signed Q8.8
//   coef_we    - coefficient write strobe
//   coef_addr  - coefficient tap index k
//   coef_wdata - coefficient value, signed Q4.16
//   fir_valid  - one-cycle strobe per valid output
//   fir_d      - filtered sample, signed Q8.8; holds its value while fir_valid=0
//   sat        - sticky flag, set by any clamped valid output
//
// Build option: define FIR_ROUND_EN to round half up before the shift.
// Without it, the shift truncates toward minus infinity. Latency is the same
// in both builds.
module fir_stream_p #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 20,
  parameter int TAPS   = 32,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    data_valid,
  input  logic [DATA_W-1:0]       data,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]       coef_wdata,
  output logic                    fir_valid,
  output logic [OUT_W-1:0]        fir_d,
  output logic                    sat
);

  localparam int AW     = $clog2(TAPS);
  localparam int CNT_W  = AW + 1;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + AW;
  // One guard bit so the rounding offset cannot wrap the accumulator.
  localparam int EXT_W  = ACC_W + 1;

  localparam logic signed [EXT_W-1:0] OUT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] OUT_MIN = ~OUT_MAX;
`ifdef FIR_ROUND_EN
  localparam logic signed [EXT_W-1:0] RND_HALF = EXT_W'(1) << (SHIFT-1);
`endif

  function automatic logic signed [EXT_W-1:0] scale_acc(input logic signed [ACC_W-1:0] acc);
    logic signed [EXT_W-1:0] t;
    t = {acc[ACC_W-1], acc};
`ifdef FIR_ROUND_EN
    t = t + RND_HALF;
`endif
    return t >>> SHIFT;
  endfunction

  function automatic logic clip_hit(input logic signed [EXT_W-1:0] v);
    return (v > OUT_MAX) || (v < OUT_MIN);
  endfunction

  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [EXT_W-1:0] v);
    if (v > OUT_MAX)      return OUT_MAX[OUT_W-1:0];
    else if (v < OUT_MIN) return OUT_MIN[OUT_W-1:0];
    else                  return v[OUT_W-1:0];
  endfunction

  logic signed [DATA_W-1:0] x_p0 [TAPS];
  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic                     wr_vld_p0;
  logic [AW-1:0]            wr_addr_p0;
  logic signed [COEF_W-1:0] wr_data_p0;
  logic [CNT_W-1:0]         warm_cnt;
  logic                     warm_done;
  logic                     addr_ok;
  logic                     vld_p0, vld_p1, vld_p2;
  logic signed [PROD_W-1:0] prod_p1 [TAPS];
  logic signed [ACC_W-1:0]  tree_sum;
  logic signed [ACC_W-1:0]  sum_p2;
  logic signed [EXT_W-1:0]  scaled;

  // An index can only exceed the tap count when TAPS is not a power of two.
  generate
    if ((1 << AW) > TAPS) begin : g_addr_chk
      assign addr_ok = (32'(coef_addr) < TAPS);
    end else begin : g_addr_all
      assign addr_ok = 1'b1;
    end
  endgenerate

  // The incoming sample is the TAPS-th or a later one.
  assign warm_done = (int'(warm_cnt) >= TAPS - 1);

  // Coefficient writes commit one edge late. The products for a sample
  // accepted on the write edge are formed on the following edge, so they
  // still read the old value. Every later sample sees the new value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) coef_q[k] <= '0;
      wr_vld_p0  <= 1'b0;
      wr_addr_p0 <= '0;
      wr_data_p0 <= '0;
    end else begin
      wr_vld_p0 <= coef_we & addr_ok;
      if (coef_we) begin
        wr_addr_p0 <= coef_addr;
        wr_data_p0 <= $signed(coef_wdata);
      end
      if (wr_vld_p0) coef_q[wr_addr_p0] <= wr_data_p0;
    end
  end

  // ---- stage p0: delay line, warm-up counter, valid tag ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) x_p0[k] <= '0;
      warm_cnt <= '0;
      vld_p0   <= 1'b0;
    end else begin
      vld_p0 <= data_valid & warm_done;
      if (data_valid) begin
        x_p0[0] <= $signed(data);
        for (int k = 1; k < TAPS; k++) x_p0[k] <= x_p0[k-1];
        if (int'(warm_cnt) != TAPS) warm_cnt <= warm_cnt + 1'b1;
      end
    end
  end

  // ---- stage p1: registered products ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) prod_p1[k] <= '0;
      vld_p1 <= 1'b0;
    end else begin
      for (int k = 0; k < TAPS; k++) prod_p1[k] <= PROD_W'(x_p0[k]) * PROD_W'(coef_q[k]);
      vld_p1 <= vld_p0;
    end
  end

  // Binary adder tree. node[1] is the root and leaves occupy node[TAPS..2*TAPS-1].
  always_comb begin : adder_tree
    logic signed [ACC_W-1:0] node [1:2*TAPS-1];
    for (int k = 0; k < TAPS; k++) node[TAPS+k] = ACC_W'(prod_p1[k]);
    for (int i = TAPS - 1; i >= 1; i--) node[i] = node[2*i] + node[2*i+1];
    tree_sum = node[1];
  end

  // ---- stage p2: registered sum ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_p2 <= '0;
      vld_p2 <= 1'b0;
    end else begin
      sum_p2 <= tree_sum;
      vld_p2 <= vld_p1;
    end
  end

  assign scaled = scale_acc(sum_p2);

  // ---- output stage: scale, saturate, sticky flag ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fir_valid <= 1'b0;
      fir_d     <= '0;
      sat       <= 1'b0;
    end else begin
      fir_valid <= vld_p2;
      if (vld_p2) begin
        fir_d <= saturate(scaled);
        if (clip_hit(scaled)) sat <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_stream_p.sv
`timescale 1ns/1ps
module tb_fir_stream_p;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_valid;
  logic [15:0] data;
  logic        coef_we;
  logic [4:0]  coef_addr;
  logic [19:0] coef_wdata;
  logic        fir_valid;
  logic [15:0] fir_d;
  logic        sat;

  fir_stream_p dut (
    .clk       (clk),
    .rst       (rst),
    .data_valid(data_valid),
    .data      (data),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_wdata(coef_wdata),
    .fir_valid (fir_valid),
    .fir_d     (fir_d),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] d;
    logic        s;
    int          acc_cyc;
  } exp_t;

  typedef struct {
    string       name;
    int          cmode;
    logic [15:0] din;
    logic [15:0] exp_d;
    logic        exp_sat;
  } vec_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] obs_q[$];
  logic [15:0] ref_q[$];
  vec_t        vt[7];

  logic signed [15:0] mx[32];
  logic signed [19:0] mc[32];
  int                 mcnt;
  logic               msat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 32; k++) begin
      mx[k] = '0;
      mc[k] = '0;
    end
    mcnt = 0;
    msat = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic model_accept(input logic [15:0] s);
    longint acc, xv, cv;
    exp_t   e;
    for (int k = 31; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = s;
    if (mcnt < 32) mcnt++;
    if (mcnt == 32) begin
      acc = 0;
      for (int k = 0; k < 32; k++) begin
        xv = mx[k];
        cv = mc[k];
        acc += xv * cv;
      end
`ifdef FIR_ROUND_EN
      acc += 64'sd32768;
`endif
      acc = acc >>> 16;
      if (acc > 32767) begin
        e.d = 16'h7FFF;
        msat = 1'b1;
      end else if (acc < -32768) begin
        e.d = 16'h8000;
        msat = 1'b1;
      end else begin
        e.d = acc[15:0];
      end
      e.s = msat;
      e.acc_cyc = cyc + 1;
      exp_q.push_back(e);
    end
  endtask

  // Output monitor: every strobe is checked against the scoreboard head.
  always @(negedge clk) begin
    if (rst === 1'b1 && fir_valid === 1'b1) begin
      obs_q.push_back(fir_d);
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'(fir_d), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_fir_d", 32'(fir_d), 32'(mon_e.d));
        chk("sb_sat", 32'(sat), 32'(mon_e.s));
        chk("sb_latency", cyc - mon_e.acc_cyc, 32'd3);
      end
    end
  end

  task automatic drive(input logic v, input logic [15:0] s, input logic we,
                       input logic [4:0] a, input logic [19:0] w);
    @(negedge clk);
    data_valid = v;
    data       = s;
    coef_we    = we;
    coef_addr  = a;
    coef_wdata = w;
    if (v) model_accept(s);
    if (we) mc[a] = w;
  endtask

  task automatic send(input logic [15:0] s);
    drive(1'b1, s, 1'b0, 5'd0, 20'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 16'h0000, 1'b0, 5'd0, 20'd0);
  endtask

  function automatic logic [19:0] coef_of(input int mode, input int k);
    case (mode)
      0:       return 20'h10000;
      1:       return (k == 0) ? 20'h08000 : 20'h00000;
      3:       return 20'(k * 4096);
      default: return 20'h00000;
    endcase
  endfunction

  task automatic load(input int mode);
    for (int k = 0; k < 32; k++) drive(1'b0, 16'h0000, 1'b1, 5'(k), coef_of(mode, k));
  endtask

  task automatic do_reset();
    @(negedge clk);
    data_valid = 1'b0;
    coef_we    = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_fir_valid", 32'(fir_valid), 32'd0);
    chk("rst_fir_d", 32'(fir_d), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    model_reset();
    @(negedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic setv(input int i, input string name, input int cmode, input logic [15:0] din,
                      input logic [15:0] exp_d, input logic exp_sat);
    vt[i].name    = name;
    vt[i].cmode   = cmode;
    vt[i].din     = din;
    vt[i].exp_d   = exp_d;
    vt[i].exp_sat = exp_sat;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] r;
    rst        = 1'b0;
    data_valid = 1'b0;
    data       = '0;
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_wdata = '0;
    model_reset();

    // cmode: 0 = all 1.0, 1 = c[0]=0.5 only, 2 = all zero, 3 = c[k]=k/16
    setv(0, "warmup",    0, 16'h0100, 16'h2000, 1'b0);
    setv(1, "pos_sat",   0, 16'h7FFF, 16'h7FFF, 1'b1);
    setv(2, "neg_sat",   0, 16'h8000, 16'h8000, 1'b1);
`ifdef FIR_ROUND_EN
    setv(3, "round_pos", 1, 16'h0001, 16'h0001, 1'b0);
    setv(4, "round_neg", 1, 16'hFFFF, 16'h0000, 1'b0);
`else
    setv(3, "round_pos", 1, 16'h0001, 16'h0000, 1'b0);
    setv(4, "round_neg", 1, 16'hFFFF, 16'hFFFF, 1'b0);
`endif
    setv(5, "neg_unity", 0, 16'hFF00, 16'hE000, 1'b0);
    setv(6, "zero_coef", 2, 16'h1234, 16'h0000, 1'b0);

    for (int i = 0; i < 7; i++) begin
      do_reset();
      load(vt[i].cmode);
      repeat (31) send(vt[i].din);
      idle(4);
      chk({vt[i].name, "_warm_none"}, 32'(obs_q.size()), 32'd0);
      send(vt[i].din);
      idle(4);
      chk({vt[i].name, "_valid"}, 32'(fir_valid), 32'd1);
      chk({vt[i].name, "_d"}, 32'(fir_d), 32'(vt[i].exp_d));
      chk({vt[i].name, "_sat"}, 32'(sat), 32'(vt[i].exp_sat));
      idle(3);
      chk({vt[i].name, "_idle_valid"}, 32'(fir_valid), 32'd0);
      chk({vt[i].name, "_hold"}, 32'(fir_d), 32'(vt[i].exp_d));
    end

    // Impulse response: one non-zero sample walks through every tap.
    do_reset();
    load(3);
    repeat (31) send(16'h0000);
    send(16'h0100);
    repeat (33) send(16'h0000);
    idle(6);
    chk("impulse_count", 32'(obs_q.size()), 32'd34);
    for (int k = 0; k < 34; k++)
      chk("impulse_tap", (k < obs_q.size()) ? 32'(obs_q[k]) : 32'hDEAD,
          (k < 32) ? 32'(k * 16) : 32'd0);

    // Continuous reference run, then the same samples on every other cycle.
    do_reset();
    load(3);
    for (int i = 0; i < 40; i++) begin
      r = 16'(i * 64 - 1024);
      send(r);
    end
    idle(6);
    ref_q = obs_q;
    chk("cont_count", 32'(ref_q.size()), 32'd9);
    do_reset();
    load(3);
    for (int i = 0; i < 40; i++) begin
      r = 16'(i * 64 - 1024);
      send(r);
      idle(1);
    end
    idle(6);
    chk("gap_count", 32'(obs_q.size()), 32'd9);
    for (int k = 0; k < 9; k++)
      chk("gap_vs_cont", (k < obs_q.size()) ? 32'(obs_q[k]) : 32'hDEAD,
          (k < ref_q.size()) ? 32'(ref_q[k]) : 32'hBEEF);

    // Coefficient write on the same edge as the 32nd sample.
    do_reset();
    load(0);
    repeat (31) send(16'h0100);
    drive(1'b1, 16'h0100, 1'b1, 5'd0, 20'h20000);
    send(16'h0100);
    idle(6);
    chk("collide_count", 32'(obs_q.size()), 32'd2);
    chk("collide_old_c", (obs_q.size() > 0) ? 32'(obs_q[0]) : 32'hDEAD, 32'h2000);
    chk("collide_new_c", (obs_q.size() > 1) ? 32'(obs_q[1]) : 32'hDEAD, 32'h2100);

    // Reset in the middle of a saturating stream with outputs in flight.
    do_reset();
    load(0);
    repeat (35) send(16'h7FFF);
    idle(1);
    chk("mid_sat_before", 32'(sat), 32'd1);
    do_reset();
    idle(6);
    chk("mid_no_inflight", 32'(obs_q.size()), 32'd0);
    repeat (31) send(16'h0100);
    idle(4);
    chk("mid_rewarm_none", 32'(obs_q.size()), 32'd0);
    send(16'h0100);
    idle(4);
    chk("mid_valid", 32'(fir_valid), 32'd1);
    chk("mid_coef_cleared", 32'(fir_d), 32'd0);
    chk("mid_sat_after", 32'(sat), 32'd0);

    idle(8);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
